sid_waveform_mixer: RTL
=======================

# sid_waveform_mixer

Combines the per-voice waveform components from `sid_waveform` (selector, noise, pulse, saw_tri) into the 12-bit waveform value that drives the voice DAC, and the 8-bit OSC3 readback value.
- Combined waveforms are a bitwise AND of the selected components.
- With no waveform selected, the output floats: it holds its last value, then fades on a model-dependent timer.
- Sits directly downstream of `sid_waveform`, one instance per voice. Its output feeds the voice DAC / envelope multiply and the OSC3 register read path.

## Interface
Parameters:
- `FADE_6581`, 54000, SID cycles a floating output holds on 6581 before it clears to zero.
- `FADE_8580`, 800000, SID cycles between fade steps on 8580.
- `CNT_W`, 20, fade counter width. Must hold `max(FADE_6581, FADE_8580)`.

Ports:
- `clk` in 1: system clock.
- `res` in 1: reset, asynchronous, active-high.
- `model` in `sid::model_e`: `MOS6581` / `MOS8580`.
- `phase` in `sid::phase_t`: one-hot SID cycle phase.
- `wav_i` in `sid::waveform_i_t`: `selector[3:0]` = {noise, pulse, saw, tri}, `noise[7:0]`, `pulse`, `saw_tri[11:0]`.
- `wav_o` out 12: mixed waveform value to the DAC.
- `osc3` out 8: `wav_o[11:4]`, for the OSC3 read.

## Operation
Component expansion (all components 12 bits wide):
- tri = `{saw_tri[10:0], 1'b0}`
- saw = `saw_tri`
- pulse = `{12{pulse}}`
- noise = `{noise[7:0], 4'b0}`

Mix:
- `mix` = bitwise AND of every component whose selector bit is set.
- `selector == 0` means floating; `mix` is not used in that case.

State:
- `wav_q[11:0]`
- `fade_cnt[CNT_W-1:0]`
- `floating` flag

FSM, states DRIVEN and FLOAT. Evaluated only when `phase[sid::PHI2]` is set; all state holds in every other phase.
- **DRIVEN, selector != 0:**
  - `wav_q <= mix`.
  - Stay in DRIVEN.
- **DRIVEN, selector == 0:**
  - `wav_q` holds.
  - `fade_cnt <= (model==MOS6581 ? FADE_6581 : FADE_8580) - 1`.
  - Go to FLOAT.
- **FLOAT, selector != 0:**
  - `wav_q <= mix` on the same PHI2.
  - Go to DRIVEN; `fade_cnt` is don't-care.
- **FLOAT, selector == 0, fade_cnt != 0:**
  - `fade_cnt` decrements by 1.
  - `wav_q` holds.
- **FLOAT, selector == 0, fade_cnt == 0:**
  - 6581: `wav_q <= 0`. Stay in FLOAT; the counter stays 0 and `wav_q` stays 0.
  - 8580: `wav_q <= wav_q & (wav_q >> 1)` and `fade_cnt <= FADE_8580 - 1`. Stay in FLOAT, so the value fades again every `FADE_8580` cycles until it reaches 0.

Other rules:
- `wav_q == 0` while floating causes no extra behaviour; counting continues harmlessly.
- A `model` change mid-FLOAT affects only the next reload and the next expiry action.
- The counter never wraps: decrement happens only when the counter is nonzero.

Outputs are registered: `wav_o = wav_q`, `osc3 = wav_q[11:4]`.

Reset (async) sets:
- `wav_q = 0`, `fade_cnt = 0`, state DRIVEN.
- On the first PHI2 after release, the block behaves per the DRIVEN rows.
- Reset asserted mid-FLOAT aborts the fade immediately.

## Timing
- One register stage. `wav_o` reflects the `wav_i` sampled at the clock edge where `phase[sid::PHI2]` is high, and is stable for the rest of the SID cycle.
- Because updates land at PHI2, an OSC3 read at PHI2 returns the value from the previous SID cycle. This is intended: the read precedes the update.
- 8580 `saw_tri` already carries its own one-cycle latch delay; the mixer adds none beyond its register.
- Floating lifetime:
  - 6581: selector goes 0 at PHI2 of cycle N; `wav_o` clears at PHI2 of cycle N + `FADE_6581`.
  - 8580: first fade step at N + `FADE_8580`, subsequent steps every `FADE_8580` cycles.
- A selector change and a counter expiry on the same PHI2: the nonzero selector wins, and `mix` is loaded.

## Structure
- Add to package `sid`:
  - `waveform_o_t`: struct {`wav[11:0]`, `osc3[7:0]`}.
  - `FADE_6581_DEFAULT` and `FADE_8580_DEFAULT` constants.
  - `mixer_state_e` enum {`DRIVEN`, `FLOAT`}.
- One natural sub-module, `sid_waveform_fade`, owning `fade_cnt`, the model-dependent reload, and the expiry strobe. The mixer top owns `mix` and `wav_q`.

## Test plan
- **Mixing:** saw only, `saw_tri='hABC` -> `wav_o='hABC`, `osc3='hAB`. Tri only, same input -> `'h578`. Pulse+saw, pulse=0 -> `'h000`. Noise+saw, `noise='hFF`, `saw_tri='h0F0` -> `'h0F0`.
- **6581 float** (FADE_6581=4): saw `'h800` then selector=0 -> `wav_o` holds `'h800` for PHI2s 1-3, reads `'h000` from the 4th PHI2.
- **8580 float** (FADE_8580=2): `wav_o='hFFF`, selector=0 -> after 2 cycles `'h7FF`, after 4 cycles `'h3FF`, continuing down to `'h000`.
- **Reselect at expiry:** on the exact expiry PHI2, select saw `'h123` -> `wav_o='h123`, state DRIVEN.
- **Phase gating:** change `wav_i` in non-PHI2 phases -> `wav_o` changes only at PHI2.
- **Reset mid-float:** assert `res` asynchronously between clock edges -> `wav_o=0` immediately. After release, selector=0 -> a full new fade period elapses before any expiry action.

Source files
------------

// File: rtl/sid_waveform_mixer_pkg.sv
// -----------------------------------------------------------------------------
// sid : shared types for the SID voice waveform path.
//
// Purpose
//   Types, constants and a mixing helper shared by sid_waveform_mixer and its
//   fade sub-module (and by the upstream sid_waveform generator).
//
// Contents
//   model_e        chip model, MOS6581 / MOS8580
//   phase_t        one-hot SID cycle phase, PHI2 is the update phase
//   waveform_i_t   per-voice components: selector {noise,pulse,saw,tri},
//                  noise[7:0], pulse, saw_tri[11:0]
//   waveform_o_t   mixed output: wav[11:0], osc3[7:0]
//   mixer_state_e  DRIVEN / FLOAT
//   mix_components bitwise AND of the selected 12-bit components
// -----------------------------------------------------------------------------
package sid;

    typedef enum logic {
        MOS6581 = 1'b0,
        MOS8580 = 1'b1
    } model_e;

    // Four clock phases per SID cycle; only PHI2 moves waveform state.
    localparam int NUM_PHASES = 4;
    localparam int PHI1       = 0;
    localparam int PHI2       = 2;

    typedef logic [NUM_PHASES-1:0] phase_t;

    // Selector bit positions inside waveform_i_t.selector.
    localparam int SEL_TRI   = 0;
    localparam int SEL_SAW   = 1;
    localparam int SEL_PULSE = 2;
    localparam int SEL_NOISE = 3;

    typedef struct packed {
        logic [3:0]  selector;
        logic [7:0]  noise;
        logic        pulse;
        logic [11:0] saw_tri;
    } waveform_i_t;

    typedef struct packed {
        logic [11:0] wav;
        logic [7:0]  osc3;
    } waveform_o_t;

    localparam int FADE_6581_DEFAULT = 54000;
    localparam int FADE_8580_DEFAULT = 800000;

    typedef enum logic {
        DRIVEN = 1'b0,
        FLOAT  = 1'b1
    } mixer_state_e;

    // Combined waveforms are the AND of every selected component. With no
    // selector bit set the result is all ones, but the caller never uses it
    // in that case (the output floats instead).
    function automatic logic [11:0] mix_components(input waveform_i_t w);
        logic [11:0] r;
        r = 12'hFFF;
        if (w.selector[SEL_TRI])   r = r & {w.saw_tri[10:0], 1'b0};
        if (w.selector[SEL_SAW])   r = r & w.saw_tri;
        if (w.selector[SEL_PULSE]) r = r & {12{w.pulse}};
        if (w.selector[SEL_NOISE]) r = r & {w.noise, 4'b0000};
        return r;
    endfunction

endpackage

// File: rtl/sid_waveform_fade.sv
// -----------------------------------------------------------------------------
// sid_waveform_fade : floating-output timer for one voice.
//
// Purpose
//   Owns the fade counter. Loaded with the model-dependent period minus one
//   when the output starts floating, counts down once per floating PHI2 and
//   raises o_expire on the floating PHI2 where the counter is already zero.
//   On 8580 the expiry reloads the counter so the fade repeats; on 6581 the
//   counter parks at zero.
//
// Ports
//   clk       in   system clock
//   res       in   asynchronous active-high reset
//   i_model   in   chip model, selects reload value / expiry behaviour
//   i_load    in   PHI2 on which the output starts floating
//   i_step    in   PHI2 on which the output keeps floating
//   o_expire  out  combinational strobe: i_step with the counter at zero
// -----------------------------------------------------------------------------
import sid::*;

module sid_waveform_fade #(
    parameter int FADE_6581 = FADE_6581_DEFAULT,
    parameter int FADE_8580 = FADE_8580_DEFAULT,
    parameter int CNT_W     = 20
) (
    input  logic   clk,
    input  logic   res,
    input  model_e i_model,
    input  logic   i_load,
    input  logic   i_step,
    output logic   o_expire
);

    localparam logic [CNT_W-1:0] RELOAD_6581 = CNT_W'(FADE_6581 - 1);
    localparam logic [CNT_W-1:0] RELOAD_8580 = CNT_W'(FADE_8580 - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_reload;
    logic             w_zero;

    assign w_reload = (i_model == MOS6581) ? RELOAD_6581 : RELOAD_8580;
    assign w_zero   = (r_cnt == '0);
    assign o_expire = i_step && w_zero;

    // Decrement only while nonzero so the counter never wraps.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= w_reload;
        end else if (i_step) begin
            if (!w_zero) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else if (i_model == MOS8580) begin
                r_cnt <= RELOAD_8580;
            end
        end
    end

endmodule

// File: rtl/sid_waveform_mixer.sv
// -----------------------------------------------------------------------------
// sid_waveform_mixer : per-voice waveform combiner.
//
// Purpose
//   ANDs the selected waveform components into the 12-bit value for the voice
//   DAC and the 8-bit OSC3 readback. With no waveform selected the output
//   floats: it holds, then fades on a model-dependent timer (6581 clears to
//   zero once, 8580 shifts bits away step by step).
//
// Handshake
//   No valid/ready: the block samples wav_i on every clock edge where
//   phase[PHI2] is high and holds all state on every other edge, so wav_o is
//   stable for the remainder of the SID cycle.
//
// Ports
//   clk          in   system clock
//   res          in   asynchronous active-high reset
//   model        in   chip model (MOS6581 / MOS8580)
//   phase        in   one-hot SID cycle phase
//   wav_i        in   waveform components and selector
//   wav_o        out  registered mixed waveform, 12 bits
//   osc3         out  wav_o[11:4] for the OSC3 read
//   o_dbg_state  out  current FSM state (DRIVEN / FLOAT)
// -----------------------------------------------------------------------------
import sid::*;

module sid_waveform_mixer #(
    parameter int FADE_6581 = FADE_6581_DEFAULT,
    parameter int FADE_8580 = FADE_8580_DEFAULT,
    parameter int CNT_W     = 20
) (
    input  logic         clk,
    input  logic         res,
    input  model_e       model,
    input  phase_t       phase,
    input  waveform_i_t  wav_i,
    output logic [11:0]  wav_o,
    output logic [7:0]   osc3,
    output mixer_state_e o_dbg_state
);

    mixer_state_e r_state;
    logic [11:0]  r_wav;

    logic         w_phi2;
    logic         w_selected;
    logic [11:0]  w_mix;
    logic         w_load;
    logic         w_step;
    logic         w_expire;
    waveform_o_t  w_out;
    logic [NUM_PHASES-1:0] w_unused_phase;

    assign w_phi2         = phase[PHI2];
    assign w_unused_phase = phase;
    assign w_selected     = |wav_i.selector;
    assign w_mix          = mix_components(wav_i);

    // The timer starts on the PHI2 that deselects everything and steps on
    // every later deselected PHI2.
    assign w_load = w_phi2 && (r_state == DRIVEN) && !w_selected;
    assign w_step = w_phi2 && (r_state == FLOAT)  && !w_selected;

    sid_waveform_fade #(
        .FADE_6581 (FADE_6581),
        .FADE_8580 (FADE_8580),
        .CNT_W     (CNT_W)
    ) u_fade (
        .clk      (clk),
        .res      (res),
        .i_model  (model),
        .i_load   (w_load),
        .i_step   (w_step),
        .o_expire (w_expire)
    );

    // A nonzero selector always wins, including on the expiry PHI2, because
    // w_step (and so w_expire) is qualified by an empty selector.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= DRIVEN;
            r_wav   <= '0;
        end else if (w_phi2) begin
            case (r_state)
                DRIVEN: begin
                    if (w_selected) begin
                        r_wav <= w_mix;
                    end else begin
                        r_state <= FLOAT;
                    end
                end
                FLOAT: begin
                    if (w_selected) begin
                        r_wav   <= w_mix;
                        r_state <= DRIVEN;
                    end else if (w_expire) begin
                        if (model == MOS6581) begin
                            r_wav <= '0;
                        end else begin
                            r_wav <= r_wav & (r_wav >> 1);
                        end
                    end
                end
                default: begin
                    r_state <= DRIVEN;
                end
            endcase
        end
    end

    assign w_out.wav  = r_wav;
    assign w_out.osc3 = r_wav[11:4];

    assign wav_o       = w_out.wav;
    assign osc3        = w_out.osc3;
    assign o_dbg_state = r_state;

endmodule
